aes_out_serializer: RTL and testbench
=====================================

AES_OUT_SERIALIZER -- requirements
Module: aes_out_serializer

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning output word width; only 32 is supported (128/WORD_W = 4 words per block).
REQ-002 SHALL have port AES_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port AES_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port AES_data_out_valid  input  1  cipher-core result-valid level/pulse.
REQ-005 SHALL have port AES_data_out  input  128  cipher-core result block.
REQ-006 SHALL have port ser_ready  input  1  downstream accepts the current word.
REQ-007 SHALL have port ser_clr  input  1  synchronous clear of the overflow flag.
REQ-008 SHALL have port ser_data  output  32  current output word.
REQ-009 SHALL have port ser_valid  output  1  ser_data holds a valid word.
REQ-010 SHALL have port ser_last  output  1  current word is the final word of a block.
REQ-011 SHALL have port ser_busy  output  1  a block is being sent or is pending.
REQ-012 SHALL have port ser_overflow  output  1  sticky: a block was dropped.

Function
REQ-013 SHALL register AES_data_out_valid into prev_v; capture event = AES_data_out_valid & ~prev_v, so a held-high valid yields one event.
REQ-014 SHALL hold two 128-bit stores: shift register SR (block in transmission) and one-entry pending buffer PB with flag pb_full.
REQ-015 SHALL implement FSM states IDLE and SEND, plus 2-bit word counter cnt.
REQ-016 IDLE + capture event: SR <= AES_data_out, cnt <= 0, state <= SEND; ser_valid high from the following cycle (latency 1 clock).
REQ-017 SEND: ser_valid = 1; ser_data = SR[127:96] when cnt=0, [95:64] when cnt=1, [63:32] when cnt=2, [31:0] when cnt=3 (MS word first).
REQ-018 Transfer occurs when ser_valid & ser_ready; cnt increments by 1 per transfer; with no transfer, ser_data, ser_last and cnt SHALL hold unchanged.
REQ-019 ser_last = ser_valid & (cnt == 3).
REQ-020 Transfer of last word with pb_full=1: SR <= PB, pb_full <= 0, cnt <= 0, stay SEND (no idle cycle between blocks).
REQ-021 Transfer of last word with pb_full=0 and no capture event: state <= IDLE, ser_valid low next cycle.
REQ-022 Capture event in SEND, not coinciding with a last-word transfer: if pb_full=0, PB <= AES_data_out, pb_full <= 1; if pb_full=1, block dropped and ser_overflow <= 1.
REQ-023 Capture event coinciding with last-word transfer: if pb_full=0, SR <= AES_data_out, cnt <= 0, stay SEND; if pb_full=1, SR <= PB and PB <= AES_data_out (pb_full stays 1), no overflow.
REQ-024 ser_clr=1 clears ser_overflow next edge; a simultaneous new overflow event wins (flag stays 1).
REQ-025 ser_busy = (state == SEND) | pb_full.
REQ-026 ser_ready SHALL be ignored while ser_valid=0.

Reset
REQ-027 On AES_rst_n=0, immediately and regardless of clock: state=IDLE, cnt=0, pb_full=0, prev_v=0, SR=0, PB=0, ser_data=0, ser_valid=0, ser_last=0, ser_busy=0, ser_overflow=0.
REQ-028 Reset mid-block SHALL discard SR and PB contents; if AES_data_out_valid is high at reset release, the first edge after release counts as a capture event (prev_v=0).

Verification
REQ-029 Block 128'h00112233_44556677_8899aabb_ccddeeff, ser_ready=1 -> ser_valid for 4 consecutive cycles starting 1 cycle after capture; words 00112233, 44556677, 8899aabb, ccddeeff; ser_last only on the 4th; then IDLE.
REQ-030 Same block, ser_ready toggling 1,0,0,1,1,0,1 -> each word held stable while stalled; exactly 4 transfers in order; ser_last on the 4th transfer only.
REQ-031 AES_data_out_valid held high 51 cycles with a constant block -> exactly one block (4 words) emitted, ser_overflow=0.
REQ-032 Three capture events (A, B, C) within block A's first word, ser_ready=0 -> A in SR, B in PB, C dropped, ser_overflow=1; with ser_ready=1 afterwards -> A then B back-to-back (8 words, no gap); ser_clr pulse -> ser_overflow=0.
REQ-033 Capture event on the same edge as A's last-word transfer, pb_full=0 -> new block's word 0 presented on the next cycle, ser_valid never drops.
REQ-034 AES_rst_n asserted after 2 words of a block with PB full -> all outputs 0 asynchronously; after release with AES_data_out_valid=0, no words emitted.

Source files
------------

// File: rtl/aes_out_serializer.sv
// aes_out_serializer: splits 128-bit cipher results into four 32-bit words, MS word first, with valid/ready handshake
// Ports:
//   AES_clk, AES_rst_n           clock, async active-low reset
//   AES_data_out_valid/_out      cipher-core result strobe and 128-bit block
//   ser_ready, ser_clr           downstream accept, overflow-flag clear
//   ser_data/valid/last          current word, its valid, final-word marker
//   ser_busy, ser_overflow       block in flight or pending, sticky drop flag
module aes_out_serializer #(
  parameter int WORD_W = 32
) (
  input  logic              AES_clk,
  input  logic              AES_rst_n,
  input  logic              AES_data_out_valid,
  input  logic [127:0]      AES_data_out,
  input  logic              ser_ready,
  input  logic              ser_clr,
  output logic [WORD_W-1:0] ser_data,
  output logic              ser_valid,
  output logic              ser_last,
  output logic              ser_busy,
  output logic              ser_overflow
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t       r_state;
  logic [1:0]   r_cnt;
  logic         r_pb_full;
  logic         r_prev_v;
  logic         r_ovf;
  logic [127:0] r_sr;
  logic [127:0] r_pb;
  logic         w_cap;
  logic         w_xfer;
  logic         w_last;
  assign w_cap        = AES_data_out_valid & ~r_prev_v;
  assign ser_valid    = (r_state == SEND);
  assign ser_last     = ser_valid & (r_cnt == 2'd3);
  assign ser_busy     = ser_valid | r_pb_full;
  assign ser_overflow = r_ovf;
  assign w_xfer       = ser_valid & ser_ready;
  assign w_last       = w_xfer & (r_cnt == 2'd3);
  // cnt=0 selects bits [127:96]; inverting cnt turns word order into a bit offset
  assign ser_data     = r_sr[{~r_cnt, 5'd0} +: WORD_W];
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 2'd0;
      r_pb_full <= 1'b0;
      r_prev_v  <= 1'b0;
      r_ovf     <= 1'b0;
      r_sr      <= '0;
      r_pb      <= '0;
    end else begin
      r_prev_v <= AES_data_out_valid;
      if (ser_clr) r_ovf <= 1'b0;
      if (r_state == IDLE) begin
        if (w_cap) begin
          r_sr    <= AES_data_out;
          r_cnt   <= 2'd0;
          r_state <= SEND;
        end
      end else if (w_last) begin
        r_cnt <= 2'd0;
        if (r_pb_full) begin
          // pending block moves up; a coincident capture refills the buffer
          r_sr <= r_pb;
          if (w_cap) r_pb <= AES_data_out;
          else r_pb_full <= 1'b0;
        end else if (w_cap) begin
          r_sr <= AES_data_out;
        end else begin
          r_state <= IDLE;
        end
      end else begin
        if (w_xfer) r_cnt <= r_cnt + 2'd1;
        // set after the clear so a same-cycle drop keeps the flag high
        if (w_cap && !r_pb_full) begin
          r_pb      <= AES_data_out;
          r_pb_full <= 1'b1;
        end else if (w_cap) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_out_serializer.sv
// tb_aes_out_serializer: directed self-checking bench for aes_out_serializer
module tb_aes_out_serializer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         dv = 1'b0;
  logic [127:0] din = '0;
  logic         rdy = 1'b0;
  logic         clr = 1'b0;
  logic [31:0]  sd;
  logic         sv, sl, sb, so;
  int           total = 0;
  int           bad = 0;
  localparam logic [127:0] BA = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] BB = 128'hdeadbeef_01234567_89abcdef_fedcba98;
  localparam logic [127:0] BC = 128'h0badf00d_11110000_22223333_a5a5c3c3;
  aes_out_serializer #(.WORD_W(32)) dut (
    .AES_clk(clk), .AES_rst_n(rst_n), .AES_data_out_valid(dv), .AES_data_out(din),
    .ser_ready(rdy), .ser_clr(clr), .ser_data(sd), .ser_valid(sv), .ser_last(sl),
    .ser_busy(sb), .ser_overflow(so)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [127:0] b, input int i);
    return b[127-32*i -: 32];
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    dv = 1'b0;
    rdy = 1'b0;
    clr = 1'b0;
    din = '0;
    step;
    rst_n = 1'b1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    total++; if (sv !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", sv); end
    total++; if (sd !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", sd); end
    total++; if (sl !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", sl); end
    total++; if (sb !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", sb); end
    total++; if (so !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", so); end
    do_reset;
  endtask
  task automatic test_basic;
    do_reset;
    rdy = 1'b1;
    dv = 1'b1;
    din = BA;
    total++; if (sv !== 1'b0) begin bad++; $display("FAIL basic_pre_valid got=%b exp=0", sv); end
    step;
    dv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (sv !== 1'b1) begin bad++; $display("FAIL basic_valid w%0d got=%b exp=1", i, sv); end
      total++; if (sd !== word(BA, i)) begin bad++; $display("FAIL basic_data w%0d got=%h exp=%h", i, sd, word(BA, i)); end
      total++; if (sl !== (i == 3)) begin bad++; $display("FAIL basic_last w%0d got=%b exp=%b", i, sl, i == 3); end
      total++; if (sb !== 1'b1) begin bad++; $display("FAIL basic_busy w%0d got=%b exp=1", i, sb); end
      step;
    end
    total++; if (sv !== 1'b0) begin bad++; $display("FAIL basic_idle_valid got=%b exp=0", sv); end
    total++; if (sb !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b exp=0", sb); end
    total++; if (sl !== 1'b0) begin bad++; $display("FAIL basic_idle_last got=%b exp=0", sl); end
  endtask
  task automatic test_stall;
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int w = 0;
    do_reset;
    dv = 1'b1;
    din = BA;
    step;
    dv = 1'b0;
    for (int c = 0; c < 7; c++) begin
      rdy = pat[c][0];
      total++; if (sv !== 1'b1) begin bad++; $display("FAIL stall_valid c%0d got=%b exp=1", c, sv); end
      total++; if (sd !== word(BA, w)) begin bad++; $display("FAIL stall_data c%0d got=%h exp=%h", c, sd, word(BA, w)); end
      total++; if (sl !== (w == 3)) begin bad++; $display("FAIL stall_last c%0d got=%b exp=%b", c, sl, w == 3); end
      step;
      if (pat[c] == 1) w++;
    end
    total++; if (sv !== 1'b0) begin bad++; $display("FAIL stall_end_valid got=%b exp=0", sv); end
    rdy = 1'b0;
  endtask
  task automatic test_held;
    int n = 0;
    do_reset;
    rdy = 1'b1;
    dv = 1'b1;
    din = BA;
    for (int c = 0; c < 51; c++) begin
      step;
      if (sv === 1'b1 && rdy) n++;
    end
    dv = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step;
      if (sv === 1'b1 && rdy) n++;
    end
    total++; if (n != 4) begin bad++; $display("FAIL held_words got=%0d exp=4", n); end
    total++; if (so !== 1'b0) begin bad++; $display("FAIL held_ovf got=%b exp=0", so); end
    total++; if (sv !== 1'b0) begin bad++; $display("FAIL held_end_valid got=%b exp=0", sv); end
  endtask
  task automatic test_overflow;
    logic [127:0] blk;
    do_reset;
    dv = 1'b1; din = BA; step;
    dv = 1'b0; step;
    dv = 1'b1; din = BB; step;
    dv = 1'b0; step;
    total++; if (so !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", so); end
    dv = 1'b1; din = BC; step;
    dv = 1'b0;
    total++; if (so !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", so); end
    total++; if (sv !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b exp=1", sv); end
    total++; if (sd !== word(BA, 0)) begin bad++; $display("FAIL ovf_hold got=%h exp=%h", sd, word(BA, 0)); end
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      blk = (i < 4) ? BA : BB;
      total++; if (sv !== 1'b1) begin bad++; $display("FAIL ovf_seq_valid i%0d got=%b exp=1", i, sv); end
      total++; if (sd !== word(blk, i % 4)) begin bad++; $display("FAIL ovf_seq_data i%0d got=%h exp=%h", i, sd, word(blk, i % 4)); end
      total++; if (sl !== (i % 4 == 3)) begin bad++; $display("FAIL ovf_seq_last i%0d got=%b exp=%b", i, sl, i % 4 == 3); end
      step;
    end
    total++; if (sv !== 1'b0) begin bad++; $display("FAIL ovf_end_valid got=%b exp=0", sv); end
    total++; if (sb !== 1'b0) begin bad++; $display("FAIL ovf_end_busy got=%b exp=0", sb); end
    total++; if (so !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", so); end
    clr = 1'b1; step;
    clr = 1'b0;
    total++; if (so !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", so); end
  endtask
  task automatic test_back_to_back;
    do_reset;
    rdy = 1'b1;
    dv = 1'b1; din = BA; step;
    dv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (sd !== word(BA, i)) begin bad++; $display("FAIL b2b_a_data i%0d got=%h exp=%h", i, sd, word(BA, i)); end
      if (i == 3) begin dv = 1'b1; din = BB; end
      step;
    end
    dv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (sv !== 1'b1) begin bad++; $display("FAIL b2b_valid i%0d got=%b exp=1", i, sv); end
      total++; if (sd !== word(BB, i)) begin bad++; $display("FAIL b2b_b_data i%0d got=%h exp=%h", i, sd, word(BB, i)); end
      total++; if (sl !== (i == 3)) begin bad++; $display("FAIL b2b_last i%0d got=%b exp=%b", i, sl, i == 3); end
      step;
    end
    total++; if (sv !== 1'b0) begin bad++; $display("FAIL b2b_end_valid got=%b exp=0", sv); end
  endtask
  task automatic test_swap;
    logic [127:0] blk;
    do_reset;
    dv = 1'b1; din = BA; step;
    dv = 1'b0; step;
    dv = 1'b1; din = BB; step;
    dv = 1'b0;
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (sd !== word(BA, i)) begin bad++; $display("FAIL swap_a_data i%0d got=%h exp=%h", i, sd, word(BA, i)); end
      if (i == 3) begin dv = 1'b1; din = BC; end
      step;
    end
    dv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      blk = (i < 4) ? BB : BC;
      total++; if (sv !== 1'b1) begin bad++; $display("FAIL swap_valid i%0d got=%b exp=1", i, sv); end
      total++; if (sd !== word(blk, i % 4)) begin bad++; $display("FAIL swap_data i%0d got=%h exp=%h", i, sd, word(blk, i % 4)); end
      step;
    end
    total++; if (sv !== 1'b0) begin bad++; $display("FAIL swap_end_valid got=%b exp=0", sv); end
    total++; if (so !== 1'b0) begin bad++; $display("FAIL swap_ovf got=%b exp=0", so); end
  endtask
  task automatic test_reset_mid;
    int n = 0;
    do_reset;
    dv = 1'b1; din = BA; step;
    dv = 1'b0; step;
    dv = 1'b1; din = BB; step;
    dv = 1'b0;
    rdy = 1'b1;
    step;
    step;
    rdy = 1'b0;
    total++; if (sd !== word(BA, 2)) begin bad++; $display("FAIL rmid_pre_data got=%h exp=%h", sd, word(BA, 2)); end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (sv !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", sv); end
    total++; if (sd !== 32'h0) begin bad++; $display("FAIL rmid_data got=%h exp=0", sd); end
    total++; if (sb !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", sb); end
    total++; if (sl !== 1'b0) begin bad++; $display("FAIL rmid_last got=%b exp=0", sl); end
    total++; if (so !== 1'b0) begin bad++; $display("FAIL rmid_ovf got=%b exp=0", so); end
    step;
    rst_n = 1'b1;
    rdy = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step;
      if (sv !== 1'b0 || sb !== 1'b0) n++;
    end
    total++; if (n != 0) begin bad++; $display("FAIL rmid_after got=%0d active cycles exp=0", n); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_held;
    test_overflow;
    test_back_to_back;
    test_swap;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
